// File: rtl/wb_scoreboard_if.sv
// Bundle of the issue, ALU/LSU writeback and register-file write signals around
// the writeback scoreboard. The master side is the pipeline; the slave side is the scoreboard.
interface wb_scoreboard_if #(
    parameter int WIDTH = 64
);
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic [4:0]       issue_rs1;
    logic [4:0]       issue_rs2;
    logic             issue_ready;

    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [WIDTH-1:0] alu_data;
    logic             alu_ready;

    logic             lsu_valid;
    logic [4:0]       lsu_rd;
    logic [WIDTH-1:0] lsu_data;
    logic             lsu_ready;

    logic [30:0]      wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [30:0]      busy;
    logic [4:0]       pending_cnt;
    logic             wb_err;

    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  issue_ready, alu_ready, lsu_ready,
        input  wr_en, wr_data, busy, pending_cnt, wb_err
    );

    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output issue_ready, alu_ready, lsu_ready,
        output wr_en, wr_data, busy, pending_cnt, wb_err
    );
endinterface

// File: rtl/wb_scoreboard.sv
// Writeback arbiter and busy-bit scoreboard in front of the x1..x31 register file.
// Stalls issue on RAW/WAW hazards and round-robins ALU/LSU results onto one write port.
module wb_scoreboard #(
    parameter int WIDTH       = 64,
    parameter int MAX_PENDING = 8
) (
    input logic            clk,
    input logic            rst,
    wb_scoreboard_if.slave bus
);

    localparam logic [4:0] MAX_PEND = 5'(MAX_PENDING);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    logic [30:0]      busy_q,    busy_d;
    logic [4:0]       cnt_q,     cnt_d;
    logic [30:0]      wr_en_q,   wr_en_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             wb_err_q,  wb_err_d;
    src_e             rr_last_q, rr_last_d;

    logic [31:0]      busy_ext;
    logic             rs1_haz;
    logic             rs2_haz;
    logic             rd_haz;
    logic             cap_ok;
    logic             issue_ready;
    logic             issue_fire;

    logic             conflict;
    logic             alu_gnt;
    logic             lsu_gnt;
    logic             wb_fire;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;

    logic [30:0]      set_vec;
    logic [30:0]      clr_vec;

    // x0 maps to bit 0 of a 32-bit view and is dropped, so it is never busy/written.
    function automatic logic [30:0] rd_onehot(input logic [4:0] r);
        logic [31:0] v;
        v = 32'd1 << r;
        return v[31:1];
    endfunction

    assign busy_ext = {busy_q, 1'b0};

    // Issue hazard check
    assign rs1_haz     = busy_ext[bus.issue_rs1];
    assign rs2_haz     = busy_ext[bus.issue_rs2];
    assign rd_haz      = busy_ext[bus.issue_rd];
    assign cap_ok      = (bus.issue_rd == 5'd0) || (cnt_q < MAX_PEND);
    assign issue_ready = !rs1_haz && !rs2_haz && !rd_haz && cap_ok;
    assign issue_fire  = bus.issue_valid && issue_ready;

    // Writeback arbitration: on a conflict the source that did not win last time wins.
    assign conflict = bus.alu_valid && bus.lsu_valid;
    assign alu_gnt  = bus.alu_valid && (!bus.lsu_valid || (rr_last_q == SRC_LSU));
    assign lsu_gnt  = bus.lsu_valid && (!bus.alu_valid || (rr_last_q == SRC_ALU));
    assign wb_fire  = alu_gnt || lsu_gnt;
    assign wb_rd    = lsu_gnt ? bus.lsu_rd   : bus.alu_rd;
    assign wb_data  = lsu_gnt ? bus.lsu_data : bus.alu_data;

    always_comb begin
        set_vec   = '0;
        clr_vec   = '0;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        wb_err_d  = wb_err_q;
        rr_last_d = rr_last_q;

        if (issue_fire) begin
            set_vec = rd_onehot(bus.issue_rd);
        end
        // The write in flight clears its busy bit as the register file captures it.
        // Masking with busy_q keeps a stray write to an idle register from
        // disturbing the count.
        clr_vec = wr_en_q & busy_q;
        busy_d  = (busy_q & ~clr_vec) | set_vec;

        if ((|set_vec) && !(|clr_vec)) begin
            cnt_d = cnt_q + 5'd1;
        end else if (!(|set_vec) && (|clr_vec)) begin
            cnt_d = cnt_q - 5'd1;
        end

        if (wb_fire) begin
            wr_en_d   = rd_onehot(wb_rd);
            wr_data_d = wb_data;
            if ((wb_rd != 5'd0) && !busy_ext[wb_rd]) begin
                wb_err_d = 1'b1;
            end
        end

        if (conflict) begin
            rr_last_d = alu_gnt ? SRC_ALU : SRC_LSU;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q    <= '0;
            cnt_q     <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
            wb_err_q  <= 1'b0;
            rr_last_q <= SRC_ALU;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wb_err_q  <= wb_err_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.alu_ready   = alu_gnt;
    assign bus.lsu_ready   = lsu_gnt;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.busy        = busy_q;
    assign bus.pending_cnt = cnt_q;
    assign bus.wb_err      = wb_err_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Scoreboard bench for wb_scoreboard: directed scenarios followed by random traffic,
// checked against a register-level model of pending writes and a queue of expected writes.
module tb_wb_scoreboard;

    logic clk = 1'b0;
    logic rst;

    wb_scoreboard_if #(.WIDTH(64)) bus();

    wb_scoreboard #(.WIDTH(64), .MAX_PENDING(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          rd;
        logic [63:0] data;
    } wb_t;

    wb_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          mon_en = 1'b0;

    bit          m_busy[32];
    bit          m_last_alu;
    bit          m_err;
    int          m_land;
    logic [63:0] m_held;
    bit          m_gnt_alu;
    bit          m_gnt_lsu;
    bit          m_iss_ok;

    function automatic int pending_regs();
        int n = 0;
        for (int i = 1; i < 32; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic [30:0] busy_vec();
        logic [30:0] v = '0;
        for (int i = 1; i < 32; i++) v[i-1] = m_busy[i];
        return v;
    endfunction

    function automatic bit reg_busy(int r);
        return (r != 0) && m_busy[r];
    endfunction

    function automatic logic [30:0] onehot(int r);
        logic [30:0] v = '0;
        if (r != 0) v[r-1] = 1'b1;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_last_alu = 1'b1;
        m_err      = 1'b0;
        m_land     = 0;
        m_held     = '0;
        exp_q.delete();
    endtask

    // One reset cycle with live handshakes that must all be ignored.
    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd2;
        bus.issue_rs1   = 5'd0;
        bus.issue_rs2   = 5'd0;
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd2;
        bus.alu_data    = 64'hA5A5_A5A5_A5A5_A5A5;
        bus.lsu_valid   = 1'b1;
        bus.lsu_rd      = 5'd3;
        bus.lsu_data    = 64'h5A5A_5A5A_5A5A_5A5A;
        @(posedge clk);
        model_reset();
        cyc++;
        mon_en = 1'b1;
    endtask

    task automatic step(input bit iv, input int ird, input int irs1, input int irs2,
                        input bit av, input int ard, input logic [63:0] ad,
                        input bit lv, input int lrd, input logic [63:0] ld);
        bit          old_busy[32];
        int          g_rd;
        logic [63:0] g_d;
        @(negedge clk);
        rst             = 1'b1;
        bus.issue_valid = iv;
        bus.issue_rd    = 5'(ird);
        bus.issue_rs1   = 5'(irs1);
        bus.issue_rs2   = 5'(irs2);
        bus.alu_valid   = av;
        bus.alu_rd      = 5'(ard);
        bus.alu_data    = ad;
        bus.lsu_valid   = lv;
        bus.lsu_rd      = 5'(lrd);
        bus.lsu_data    = ld;
        #1;
        m_iss_ok = !(reg_busy(irs1) || reg_busy(irs2) || reg_busy(ird)) &&
                   (ird == 0 || pending_regs() < 8);
        if (av && lv) begin
            m_gnt_alu = !m_last_alu;
            m_gnt_lsu = m_last_alu;
        end else begin
            m_gnt_alu = av;
            m_gnt_lsu = lv;
        end
        chk("issue_ready", 64'(bus.issue_ready), 64'(m_iss_ok));
        chk("alu_ready",   64'(bus.alu_ready),   64'(m_gnt_alu));
        chk("lsu_ready",   64'(bus.lsu_ready),   64'(m_gnt_lsu));
        chk("busy",        64'(bus.busy),        64'(busy_vec()));
        chk("pending_cnt", 64'(bus.pending_cnt), 64'(pending_regs()));
        chk("wb_err",      64'(bus.wb_err),      64'(m_err));
        @(posedge clk);
        old_busy = m_busy;
        if (m_land != 0) m_busy[m_land] = 1'b0;
        if (iv && m_iss_ok && ird != 0) m_busy[ird] = 1'b1;
        m_land = 0;
        if (m_gnt_alu || m_gnt_lsu) begin
            g_rd = m_gnt_alu ? ard : lrd;
            g_d  = m_gnt_alu ? ad  : ld;
            if (g_rd != 0 && !old_busy[g_rd]) m_err = 1'b1;
            exp_q.push_back('{due: cyc + 1, rd: g_rd, data: g_d});
            m_land = g_rd;
        end
        if (av && lv) m_last_alu = m_gnt_alu;
        cyc++;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0);
    endtask

    // Monitor: compares the register-file write port against queued expectations.
    initial begin
        wb_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("wr_en",   64'(bus.wr_en), 64'(onehot(e.rd)));
                chk("wr_data", bus.wr_data,    e.data);
                m_held = e.data;
            end else begin
                chk("wr_en_idle",   64'(bus.wr_en), 64'd0);
                chk("wr_data_hold", bus.wr_data,    m_held);
            end
        end
    end

    initial begin
        bit          a_v = 1'b0;
        bit          l_v = 1'b0;
        int          a_rd = 0;
        int          l_rd = 0;
        logic [63:0] a_d = '0;
        logic [63:0] l_d = '0;
        int          avail[$];
        bit          iv;
        int          ird, irs1, irs2, idx;

        rst = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
        model_reset();
        do_reset();
        do_reset();

        // Idle after reset
        #2;
        chk("rst_busy",    64'(bus.busy),        64'd0);
        chk("rst_pending", 64'(bus.pending_cnt), 64'd0);
        chk("rst_wr_en",   64'(bus.wr_en),       64'd0);
        step(0, 5, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0);

        // Single writeback round trip plus RAW stall on x5
        step(1, 5, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0);
        step(1, 0, 5, 0, 0, 0, 64'd0, 0, 0, 64'd0);
        step(1, 0, 0, 0, 1, 5, 64'hDEADBEEF_00000001, 0, 0, 64'd0);
        #2;
        chk("wr_en_x5", 64'(bus.wr_en), 64'h10);
        step(1, 0, 5, 0, 0, 0, 64'd0, 0, 0, 64'd0);
        step(1, 0, 5, 0, 0, 0, 64'd0, 0, 0, 64'd0);

        // Arbitration: LSU first after reset, then alternation on the next conflict
        do_reset();
        step(1, 3, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0);
        step(1, 7, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0);
        step(1, 4, 0, 0, 1, 3, 64'h3333, 1, 7, 64'h7777);
        #2;
        chk("conflict1_lsu", 64'(bus.wr_en), 64'h40);
        step(1, 6, 0, 0, 1, 3, 64'h3333, 0, 0, 64'd0);
        #2;
        chk("conflict1_alu", 64'(bus.wr_en), 64'h04);
        step(0, 0, 0, 0, 1, 4, 64'h4444, 1, 6, 64'h6666);
        #2;
        chk("conflict2_alu", 64'(bus.wr_en), 64'h08);
        step(0, 0, 0, 0, 0, 0, 64'd0, 1, 6, 64'h6666);
        idle();
        idle();

        // Outstanding-destination limit
        do_reset();
        for (int r = 1; r <= 8; r++) step(1, r, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0);
        #2;
        chk("pending_full", 64'(bus.pending_cnt), 64'd8);
        step(1, 9, 0, 0, 1, 1, 64'h1111, 0, 0, 64'd0);
        step(1, 9, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0);
        step(1, 9, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0);
        #2;
        chk("pending_refill", 64'(bus.pending_cnt), 64'd8);

        // Stray writeback, x0 writeback, reset with a write in flight
        do_reset();
        step(0, 0, 0, 0, 1, 9, 64'h9999, 0, 0, 64'd0);
        #2;
        chk("stray_wr_en", 64'(bus.wr_en), 64'h100);
        step(0, 0, 0, 0, 0, 0, 64'd0, 1, 0, 64'h5555);
        idle();
        idle();
        #2;
        chk("wb_err_sticky", 64'(bus.wb_err), 64'd1);
        step(1, 4, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0);
        step(1, 10, 0, 0, 1, 4, 64'h4040, 0, 0, 64'd0);
        do_reset();
        #2;
        chk("mid_rst_wr_en",   64'(bus.wr_en),       64'd0);
        chk("mid_rst_wr_data", bus.wr_data,          64'd0);
        chk("mid_rst_busy",    64'(bus.busy),        64'd0);
        chk("mid_rst_pending", 64'(bus.pending_cnt), 64'd0);
        chk("mid_rst_wb_err",  64'(bus.wb_err),      64'd0);
        idle();

        // Random traffic; sources hold each result until granted
        do_reset();
        repeat (3000) begin
            iv   = bit'($urandom_range(0, 1));
            ird  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
            irs1 = int'($urandom_range(0, 12));
            irs2 = int'($urandom_range(0, 12));
            if (!a_v) begin
                if (avail.size() > 0 && $urandom_range(0, 2) == 0) begin
                    idx = int'($urandom_range(0, avail.size() - 1));
                    a_rd = avail[idx];
                    avail.delete(idx);
                    a_v = 1'b1;
                    a_d = {$urandom, $urandom};
                end else if ($urandom_range(0, 30) == 0) begin
                    a_v = 1'b1; a_rd = 0; a_d = {$urandom, $urandom};
                end
            end
            if (!l_v) begin
                if (avail.size() > 0 && $urandom_range(0, 2) == 0) begin
                    idx = int'($urandom_range(0, avail.size() - 1));
                    l_rd = avail[idx];
                    avail.delete(idx);
                    l_v = 1'b1;
                    l_d = {$urandom, $urandom};
                end else if ($urandom_range(0, 30) == 0) begin
                    l_v = 1'b1; l_rd = 0; l_d = {$urandom, $urandom};
                end
            end
            step(iv, ird, irs1, irs2, a_v, a_rd, a_d, l_v, l_rd, l_d);
            if (m_gnt_alu) a_v = 1'b0;
            if (m_gnt_lsu) l_v = 1'b0;
            if (iv && m_iss_ok && ird != 0) avail.push_back(ird);
        end
        repeat (4) idle();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
